cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Result-broadcast arbiter that shares the single ROB writeback port (rob entry + 32-bit value) between several execution units (ALU RS, LSB, future units). Each source pushes completed results into a private 2-deep FIFO; a round-robin scheduler pops at most one result per cycle into a registered broadcast stage. The broadcast stage drives the ROB's result inputs and the RS/LSB operand-snoop logic. The ROB's mispredict flush empties the arbiter.

## Interface
- NUM_SRC, 3, number of requesting units (2..8)
- ROB_BIT, 4, ROB index width
- FIFO_DEPTH, 2, per-source FIFO depth (fixed 2; power of two)
- clk_in  input  1  system clock; single clock domain
- rst_in  input  1  synchronous, active-high reset
- rdy_in  input  1  global stall; when low all state holds
- clear_up  input  1  ROB flush (wrong prediction); honoured only when rdy_in=1
- src_valid  input  NUM_SRC  per-source result valid
- src_rob_entry  input  NUM_SRC*ROB_BIT  packed; source i at [i*ROB_BIT +: ROB_BIT]
- src_value  input  NUM_SRC*32  packed; source i at [i*32 +: 32]
- src_ready  output  NUM_SRC  per-source accept; push occurs at edge when src_valid[i] & src_ready[i]
- cdb_valid  output  1  broadcast valid (registered)
- cdb_rob_entry  output  ROB_BIT  broadcast ROB index (registered)
- cdb_value  output  32  broadcast value (registered)
- cdb_src  output  3  index of source that produced current broadcast (registered)

## Operation
- Per-source FIFO: count[i] in 0..2, wrapping read/write pointers (1 bit each).
- src_ready[i] = rdy_in & !clear_up & (count[i] != 2). Full FIFO refuses push even if popped the same cycle (no bypass).
- Request vector req[i] = (count[i] != 0). Push arriving this edge is not visible to arbitration until the next cycle.
- Round-robin: pointer rr_ptr (0..NUM_SRC-1). Search order rr_ptr, rr_ptr+1, ... mod NUM_SRC; first requester g wins.
- On grant: pop FIFO g, load cdb_rob_entry/cdb_value from FIFO g head, cdb_src<=g, cdb_valid<=1, rr_ptr <= (g+1) mod NUM_SRC.
- No requester: cdb_valid<=0; cdb_rob_entry/cdb_value/cdb_src hold; rr_ptr holds.
- Simultaneous push and pop on same FIFO: count unchanged, both pointers advance.
- Flush (clear_up & rdy_in at edge): all counts and FIFO pointers to 0, cdb_valid<=0, pushes at that edge discarded, rr_ptr holds.
- rdy_in=0: no push, no pop, no output or pointer change; cdb_valid holds its value.
- Reset (rst_in at edge, overrides everything incl. mid-burst): counts, FIFO pointers, rr_ptr, cdb_rob_entry, cdb_value, cdb_src all 0; cdb_valid=0. src_ready is 1 for every source the cycle after reset (given rdy_in=1, clear_up=0).
- FIFO data storage need not be reset.
- Assertion (simulation only): cdb_src < NUM_SRC whenever cdb_valid.

## Timing
- Push accepted at edge E0 -> earliest broadcast: registered at E1, cdb_valid high during cycle E1..E2. Latency 1 edge from acceptance to visible broadcast.
- Throughput: one broadcast per cycle total; a single source saturating alone gets one per cycle (FIFO sustains push+pop).
- With all sources continuously requesting, each is granted exactly once every NUM_SRC cycles.
- cdb_valid is a one-cycle pulse per result; the consumer has no back-pressure (ROB always accepts).
- Output valid for a result already registered before a flush edge is cleared at that edge; it is not re-sent.

## Test plan
- Reset: hold rst_in 2 cycles with src_valid=3'b111 -> cdb_valid=0, src_ready=3'b111 after release, rr_ptr=0, no push during reset.
- Single push: src 1 pushes entry 4'h5 value 32'hDEAD_BEEF at E0 -> cdb_valid=1, cdb_rob_entry=5, cdb_value=DEADBEEF, cdb_src=1 during cycle after E1; cdb_valid=0 next cycle.
- Round-robin: all 3 FIFOs preloaded with 2 results each (entries 0..5), then no pushes -> cdb_src sequence 0,1,2,0,1,2 over 6 consecutive cycles, then cdb_valid=0.
- Back-pressure: stall consumption by having src 0,1,2 push every cycle for 6 cycles -> src_ready[i] drops after its FIFO reaches 2; no result lost or duplicated, every accepted entry broadcast exactly once in per-source FIFO order.
- Flush: 4 results queued, pulse clear_up with rdy_in=1 and a concurrent push on src 2 -> next cycle cdb_valid=0, all counts 0, the concurrent push never broadcast; rr_ptr unchanged.
- Stall: rdy_in=0 for 3 cycles with cdb_valid=1 and FIFOs non-empty -> outputs, counts and rr_ptr frozen, src_ready=0; broadcasts resume in original order when rdy_in returns to 1.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single ROB writeback port between several execution units.
// Each source feeds a private 2-deep FIFO. A round-robin scheduler pops at most one
// head per cycle into a registered broadcast stage. A ROB flush empties everything.
module cdb_arbiter #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned ROB_BIT    = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       clear_up,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*ROB_BIT-1:0] src_rob_entry,
    input  logic [NUM_SRC*32-1:0]      src_value,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic                       cdb_valid,
    output logic [ROB_BIT-1:0]         cdb_rob_entry,
    output logic [31:0]                cdb_value,
    output logic [2:0]                 cdb_src
);

    localparam logic [1:0] CntFull = 2'(FIFO_DEPTH);

    // FIFO storage (not reset) and control state
    logic [ROB_BIT-1:0] ent_q [NUM_SRC][FIFO_DEPTH];
    logic [ROB_BIT-1:0] ent_d [NUM_SRC][FIFO_DEPTH];
    logic [31:0]        val_q [NUM_SRC][FIFO_DEPTH];
    logic [31:0]        val_d [NUM_SRC][FIFO_DEPTH];
    logic [1:0]         count_q [NUM_SRC];
    logic [1:0]         count_d [NUM_SRC];
    logic [NUM_SRC-1:0] wr_ptr_q, wr_ptr_d;
    logic [NUM_SRC-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]         rr_ptr_q, rr_ptr_d;

    // Broadcast stage
    logic               cdb_valid_q, cdb_valid_d;
    logic [ROB_BIT-1:0] cdb_rob_entry_q, cdb_rob_entry_d;
    logic [31:0]        cdb_value_q, cdb_value_d;
    logic [2:0]         cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               found;
    logic [2:0]         grant;

    // Accept/request per source; a full FIFO refuses even if it is popped this cycle
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = rdy_in & ~clear_up & (count_q[i] != CntFull);
            req[i]       = (count_q[i] != 2'd0);
            push[i]      = src_valid[i] & src_ready[i];
        end
    end

    // Round-robin search starting at rr_ptr_q; the first requester wins
    always_comb begin
        int idx;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= int'(NUM_SRC)) begin
                idx = idx - int'(NUM_SRC);
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!found && req[i] && (i == idx)) begin
                    found = 1'b1;
                    grant = 3'(i);
                end
            end
        end
    end

    // Next-state: flush, pushes, pop into broadcast stage, counts
    always_comb begin
        ent_d           = ent_q;
        val_d           = val_q;
        count_d         = count_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        rr_ptr_d        = rr_ptr_q;
        cdb_valid_d     = cdb_valid_q;
        cdb_rob_entry_d = cdb_rob_entry_q;
        cdb_value_d     = cdb_value_q;
        cdb_src_d       = cdb_src_q;
        pop             = '0;
        if (rdy_in) begin
            if (clear_up) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    count_d[i] = 2'd0;
                end
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                cdb_valid_d = 1'b0;
            end else begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (push[i]) begin
                        ent_d[i][wr_ptr_q[i]] = src_rob_entry[i*ROB_BIT +: ROB_BIT];
                        val_d[i][wr_ptr_q[i]] = src_value[i*32 +: 32];
                        wr_ptr_d[i]           = ~wr_ptr_q[i];
                    end
                end
                cdb_valid_d = found;
                if (found) begin
                    rr_ptr_d = (grant == 3'(NUM_SRC - 1)) ? 3'd0 : grant + 3'd1;
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (3'(i) == grant) begin
                            pop[i]          = 1'b1;
                            cdb_rob_entry_d = ent_q[i][rd_ptr_q[i]];
                            cdb_value_d     = val_q[i][rd_ptr_q[i]];
                            rd_ptr_d[i]     = ~rd_ptr_q[i];
                        end
                    end
                    cdb_src_d = grant;
                end
                for (int i = 0; i < NUM_SRC; i++) begin
                    count_d[i] = count_q[i] + 2'(push[i]) - 2'(pop[i]);
                end
            end
        end
    end

    // Control and broadcast registers with synchronous reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count_q[i] <= 2'd0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            rr_ptr_q        <= '0;
            cdb_valid_q     <= 1'b0;
            cdb_rob_entry_q <= '0;
            cdb_value_q     <= '0;
            cdb_src_q       <= '0;
        end else begin
            count_q         <= count_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            rr_ptr_q        <= rr_ptr_d;
            cdb_valid_q     <= cdb_valid_d;
            cdb_rob_entry_q <= cdb_rob_entry_d;
            cdb_value_q     <= cdb_value_d;
            cdb_src_q       <= cdb_src_d;
        end
    end

    // FIFO payload storage needs no reset; counts gate its use
    always_ff @(posedge clk_in) begin
        ent_q <= ent_d;
        val_q <= val_d;
    end

    assign cdb_valid     = cdb_valid_q;
    assign cdb_rob_entry = cdb_rob_entry_q;
    assign cdb_value     = cdb_value_q;
    assign cdb_src       = cdb_src_q;

    cdb_src_in_range: assert property (@(posedge clk_in) disable iff (rst_in)
        cdb_valid_q |-> (32'(cdb_src_q) < NUM_SRC));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single push, round-robin, back-pressure,
// flush and stall scenarios with hand-computed expectations.
module tb_cdb_arbiter;

    localparam int NS = 3;
    localparam int RB = 4;
    // Expected src_ready before each of the six saturating push edges
    localparam logic [2:0] BP_RDY [6] = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            clear_up;
    logic [NS-1:0]   src_valid;
    logic [NS*RB-1:0] src_rob_entry;
    logic [NS*32-1:0] src_value;
    logic [NS-1:0]   src_ready;
    logic            cdb_valid;
    logic [RB-1:0]   cdb_rob_entry;
    logic [31:0]     cdb_value;
    logic [2:0]      cdb_src;

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(
        .NUM_SRC    (NS),
        .ROB_BIT    (RB),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear_up      (clear_up),
        .src_valid     (src_valid),
        .src_rob_entry (src_rob_entry),
        .src_value     (src_value),
        .src_ready     (src_ready),
        .cdb_valid     (cdb_valid),
        .cdb_rob_entry (cdb_rob_entry),
        .cdb_value     (cdb_value),
        .cdb_src       (cdb_src)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input int i, input logic [3:0] e, input logic [31:0] v);
        src_rob_entry[i*RB +: RB] = e;
        src_value[i*32 +: 32]     = v;
    endtask

    task automatic test_reset();
        rst_in    = 1'b1;
        rdy_in    = 1'b1;
        clear_up  = 1'b0;
        src_valid = 3'b111;
        for (int i = 0; i < NS; i++) drive(i, 4'hC, 32'hCCCC_CCCC);
        step();
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", cdb_valid);
        end
        rst_in    = 1'b0;
        src_valid = 3'b000;
        #1;
        checks++;
        if (src_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready: got %b want 111", src_ready);
        end
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value});
        end
        checks++;
        if (dut.rr_ptr_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_rr_ptr: got %0d want 0", dut.rr_ptr_q);
        end
        step();
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_push: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_single();
        src_valid = 3'b010;
        drive(1, 4'h5, 32'hDEAD_BEEF);
        step();
        src_valid = 3'b000;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: got %b want 0", cdb_valid);
        end
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd1, 4'h5, 32'hDEAD_BEEF})
        begin
            errors++;
            $display("FAIL single_bcast: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd1, 4'h5, 32'hDEAD_BEEF});
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_src [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        logic [3:0] exp_ent [6] = '{4'd0, 4'd2, 4'd4, 4'd1, 4'd3, 4'd5};
        rst_in = 1'b1;
        step();
        rst_in    = 1'b0;
        src_valid = 3'b111;
        drive(0, 4'd0, 32'hA000_0000);
        drive(1, 4'd2, 32'hA000_0002);
        drive(2, 4'd4, 32'hA000_0004);
        step();
        drive(0, 4'd1, 32'hA000_0001);
        drive(1, 4'd3, 32'hA000_0003);
        drive(2, 4'd5, 32'hA000_0005);
        step();
        src_valid = 3'b000;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            checks++;
            if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !==
                {1'b1, exp_src[k], exp_ent[k], 32'hA000_0000 | 32'(exp_ent[k])}) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got %h want %h", k,
                         {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                         {1'b1, exp_src[k], exp_ent[k], 32'hA000_0000 | 32'(exp_ent[k])});
            end
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_back_pressure();
        int seq [3] = '{0, 0, 0};
        int s;
        int q;
        logic [39:0] exp;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) begin
                src_valid = 3'b111;
                for (int i = 0; i < NS; i++) begin
                    drive(i, {2'(i), 2'(seq[i])}, 32'hB000_0000 | 32'(i << 8) | 32'(seq[i]));
                end
                checks++;
                if (src_ready !== BP_RDY[c]) begin
                    errors++;
                    $display("FAIL bp_ready[%0d]: got %b want %b", c, src_ready, BP_RDY[c]);
                end
            end else begin
                src_valid = 3'b000;
            end
            step();
            if (c >= 1 && c <= 10) begin
                s   = (c - 1) % 3;
                q   = (c - 1) / 3;
                exp = {1'b1, 3'(s), 2'(s), 2'(q), 32'hB000_0000 | 32'(s << 8) | 32'(q)};
                checks++;
                if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== exp) begin
                    errors++;
                    $display("FAIL bp_bcast[%0d]: got %h want %h", c,
                             {cdb_valid, cdb_src, cdb_rob_entry, cdb_value}, exp);
                end
            end else begin
                checks++;
                if (cdb_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_idle[%0d]: got %b want 0", c, cdb_valid);
                end
            end
            if (c < 6) begin
                for (int i = 0; i < NS; i++) begin
                    if (BP_RDY[c][i]) seq[i]++;
                end
            end
        end
    endtask

    task automatic test_flush();
        src_valid = 3'b111;
        drive(0, 4'd1, 32'hA000_0001);
        drive(1, 4'd2, 32'hA000_0002);
        drive(2, 4'd3, 32'hA000_0003);
        step();
        src_valid = 3'b001;
        drive(0, 4'd4, 32'hA000_0004);
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd1, 4'd2, 32'hA000_0002})
        begin
            errors++;
            $display("FAIL flush_pre: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd1, 4'd2, 32'hA000_0002});
        end
        clear_up  = 1'b1;
        src_valid = 3'b100;
        drive(2, 4'hF, 32'hFFFF_FFFF);
        #1;
        checks++;
        if (src_ready !== 3'b000) begin
            errors++;
            $display("FAIL flush_ready: got %b want 000", src_ready);
        end
        step();
        clear_up  = 1'b0;
        src_valid = 3'b000;
        #1;
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid: got %b want 0", cdb_valid);
        end
        checks++;
        if (dut.rr_ptr_q !== 3'd2) begin
            errors++;
            $display("FAIL flush_rr_ptr: got %0d want 2", dut.rr_ptr_q);
        end
        checks++;
        if (src_ready !== 3'b111) begin
            errors++;
            $display("FAIL flush_empty: got %b want 111", src_ready);
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: got %b want 0", cdb_valid);
        end
        src_valid = 3'b101;
        drive(0, 4'd7, 32'hA000_0007);
        drive(2, 4'd8, 32'hA000_0008);
        step();
        src_valid = 3'b000;
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd2, 4'd8, 32'hA000_0008})
        begin
            errors++;
            $display("FAIL flush_post_a: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd2, 4'd8, 32'hA000_0008});
        end
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd0, 4'd7, 32'hA000_0007})
        begin
            errors++;
            $display("FAIL flush_post_b: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd0, 4'd7, 32'hA000_0007});
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_post_idle: got %b want 0", cdb_valid);
        end
    endtask

    task automatic test_stall();
        src_valid = 3'b111;
        drive(0, 4'd1, 32'hA000_0001);
        drive(1, 4'd2, 32'hA000_0002);
        drive(2, 4'd3, 32'hA000_0003);
        step();
        src_valid = 3'b000;
        step();
        rdy_in    = 1'b0;
        src_valid = 3'b111;
        for (int i = 0; i < NS; i++) drive(i, 4'hE, 32'hEEEE_EEEE);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (src_ready !== 3'b000) begin
                errors++;
                $display("FAIL stall_ready[%0d]: got %b want 000", k, src_ready);
            end
            step();
            checks++;
            if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !==
                {1'b1, 3'd1, 4'd2, 32'hA000_0002}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", k,
                         {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                         {1'b1, 3'd1, 4'd2, 32'hA000_0002});
            end
            checks++;
            if (dut.rr_ptr_q !== 3'd2) begin
                errors++;
                $display("FAIL stall_rr_ptr[%0d]: got %0d want 2", k, dut.rr_ptr_q);
            end
        end
        rdy_in    = 1'b1;
        src_valid = 3'b000;
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd2, 4'd3, 32'hA000_0003})
        begin
            errors++;
            $display("FAIL stall_resume_a: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd2, 4'd3, 32'hA000_0003});
        end
        step();
        checks++;
        if ({cdb_valid, cdb_src, cdb_rob_entry, cdb_value} !== {1'b1, 3'd0, 4'd1, 32'hA000_0001})
        begin
            errors++;
            $display("FAIL stall_resume_b: got %h want %h",
                     {cdb_valid, cdb_src, cdb_rob_entry, cdb_value},
                     {1'b1, 3'd0, 4'd1, 32'hA000_0001});
        end
        step();
        checks++;
        if (cdb_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_idle: got %b want 0", cdb_valid);
        end
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        clear_up      = 1'b0;
        src_valid     = '0;
        src_rob_entry = '0;
        src_value     = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_flush();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
